vertex_fetch: RTL and testbench

- Indexed vertex streamer that drives the rasterizer's vertex input.
- On start, walks an index BRAM of triangles (three 16-bit vertex indices per word) and reads each referenced vertex from a vertex BRAM.
- Emits vertices in triangle order, three per triangle, as single-cycle valid pulses of vertex_out ([3:0][31:0]: [0]=x, [1]=y, [2]=z, [3]=w/attribute, float32 passed through untouched).
- Sits between the scene memories and the rasterizer; honours the rasterizer's ready_in back-pressure.

---
 rtl/vertex_fetch.sv | 213 +++++++++++++++++++++
 tb/tb_vertex_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_fetch.sv
// Indexed vertex streamer: walks triangle index words, fetches each vertex,
// and hands vertices to the rasterizer one transfer at a time.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-low reset
//   start_in                begin a pass (sampled in IDLE only)
//   triangle_count_in       triangles in the pass, sampled with start_in
//   index_addr_out          index BRAM address, index_data_in = {v2,v1,v0}
//   vertex_addr_out         vertex BRAM address, vertex_data_in = vertex word
//   ready_in                rasterizer can accept a vertex
//   valid_out, vertex_out   registered vertex transfer ([3:0][31:0])
//   busy_out, done_out      pass in progress / one-cycle end-of-pass pulse
//   skipped_count_out       degenerate triangles skipped this pass
//
// Optional feature macro: VERTEX_FETCH_SKIP_DEGENERATE_EN
//   defined   -> triangles with repeated (truncated) indices are skipped
//   undefined -> every triangle emits three vertices, skip count stays 0
module vertex_fetch #(
    parameter int INDEX_DEPTH  = 4096,
    parameter int VERTEX_DEPTH = 4096,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            start_in,
    input  logic [15:0]                     triangle_count_in,
    output logic [$clog2(INDEX_DEPTH)-1:0]  index_addr_out,
    input  logic [47:0]                     index_data_in,
    output logic [$clog2(VERTEX_DEPTH)-1:0] vertex_addr_out,
    input  logic [127:0]                    vertex_data_in,
    input  logic                            ready_in,
    output logic                            valid_out,
    output logic [3:0][31:0]                vertex_out,
    output logic                            busy_out,
    output logic                            done_out,
    output logic [15:0]                     skipped_count_out
);

    localparam int IAW = $clog2(INDEX_DEPTH);
    localparam int VAW = $clog2(VERTEX_DEPTH);
    localparam int WW  = $clog2(BRAM_LATENCY + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(BRAM_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_INDEX,
        FETCH_VERTEX,
        EMIT,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic [15:0]          tri_q, tri_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [1:0]           k_q, k_d;
    logic [2:0][VAW-1:0]  v_q, v_d;

    logic [IAW-1:0]       iaddr_d;
    logic [VAW-1:0]       vaddr_d;
    logic [3:0][31:0]     vout_d;
    logic                 valid_d;
    logic                 done_d;
    logic                 busy_d;
    logic [15:0]          skip_d;

    logic [VAW-1:0]       cap0, cap1, cap2;
    logic                 advance;
    logic                 last_tri;
    logic                 unused_bits;

    // Indices wider than the vertex address keep only their low bits.
    assign cap0 = VAW'(index_data_in[15:0]);
    assign cap1 = VAW'(index_data_in[31:16]);
    assign cap2 = VAW'(index_data_in[47:32]);
    assign unused_bits = ^index_data_in;

    // 17-bit compare so a count of 16'hFFFF cannot wrap.
    assign last_tri = ({1'b0, tri_q} + 17'd1) >= {1'b0, cnt_q};

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q           <= IDLE;
            wait_q            <= '0;
            tri_q             <= '0;
            cnt_q             <= '0;
            k_q               <= '0;
            v_q               <= '0;
            index_addr_out    <= '0;
            vertex_addr_out   <= '0;
            vertex_out        <= '0;
            valid_out         <= 1'b0;
            done_out          <= 1'b0;
            busy_out          <= 1'b0;
            skipped_count_out <= '0;
        end else begin
            state_q           <= state_d;
            wait_q            <= wait_d;
            tri_q             <= tri_d;
            cnt_q             <= cnt_d;
            k_q               <= k_d;
            v_q               <= v_d;
            index_addr_out    <= iaddr_d;
            vertex_addr_out   <= vaddr_d;
            vertex_out        <= vout_d;
            valid_out         <= valid_d;
            done_out          <= done_d;
            busy_out          <= busy_d;
            skipped_count_out <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        tri_d   = tri_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        v_d     = v_q;
        iaddr_d = index_addr_out;
        vaddr_d = vertex_addr_out;
        vout_d  = vertex_out;
        valid_d = 1'b0;
        done_d  = 1'b0;
        skip_d  = skipped_count_out;
        advance = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    cnt_d  = triangle_count_in;
                    tri_d  = '0;
                    skip_d = '0;
                    wait_d = '0;
                    if (triangle_count_in == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        iaddr_d = '0;
                        state_d = FETCH_INDEX;
                    end
                end
            end

            FETCH_INDEX: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d = '0;
                    k_d    = '0;
                    v_d    = {cap2, cap1, cap0};
`ifdef VERTEX_FETCH_SKIP_DEGENERATE_EN
                    if (cap0 == cap1 || cap1 == cap2 || cap0 == cap2) begin
                        if (skipped_count_out != 16'hFFFF)
                            skip_d = skipped_count_out + 16'd1;
                        advance = 1'b1;
                    end else begin
                        vaddr_d = cap0;
                        state_d = FETCH_VERTEX;
                    end
`else
                    vaddr_d = cap0;
                    state_d = FETCH_VERTEX;
`endif
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end

            FETCH_VERTEX: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    vout_d  = vertex_data_in;
                    state_d = EMIT;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end

            EMIT: begin
                if (ready_in) begin
                    valid_d = 1'b1;
                    if (k_q != 2'd2) begin
                        k_d     = k_q + 2'd1;
                        vaddr_d = v_q[k_q + 2'd1];
                        state_d = FETCH_VERTEX;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end

            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Triangle finished (emitted or skipped): next index word or end.
        if (advance) begin
            if (last_tri) begin
                state_d = DONE;
            end else begin
                tri_d   = tri_q + 16'd1;
                iaddr_d = IAW'(tri_q + 16'd1);
                wait_d  = '0;
                state_d = FETCH_INDEX;
            end
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_vertex_fetch.sv
// Directed bench for vertex_fetch: table of passes plus hand sequences for
// reset-mid-pass and degenerate triangles.
module tb_vertex_fetch;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_in;
    logic [15:0]   triangle_count_in;
    logic [11:0]   index_addr_out;
    logic [47:0]   index_data_in;
    logic [11:0]   vertex_addr_out;
    logic [127:0]  vertex_data_in;
    logic          ready_in;
    logic          valid_out;
    logic [3:0][31:0] vertex_out;
    logic          busy_out;
    logic          done_out;
    logic [15:0]   skipped_count_out;

    vertex_fetch dut (
        .clk_in            (clk),
        .rst_in            (rst_n),
        .start_in          (start_in),
        .triangle_count_in (triangle_count_in),
        .index_addr_out    (index_addr_out),
        .index_data_in     (index_data_in),
        .vertex_addr_out   (vertex_addr_out),
        .vertex_data_in    (vertex_data_in),
        .ready_in          (ready_in),
        .valid_out         (valid_out),
        .vertex_out        (vertex_out),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .skipped_count_out (skipped_count_out)
    );

    always #5 clk = ~clk;

    logic [47:0]  index_mem  [0:4095];
    logic [127:0] vertex_mem [0:4095];
    logic [47:0]  ipipe0, ipipe1;
    logic [127:0] vpipe0, vpipe1;

    // Two-cycle read latency BRAM models.
    always @(posedge clk) begin
        ipipe0 <= index_mem[index_addr_out];
        ipipe1 <= ipipe0;
        vpipe0 <= vertex_mem[vertex_addr_out];
        vpipe1 <= vpipe0;
    end
    assign index_data_in  = ipipe1;
    assign vertex_data_in = vpipe1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] got_d[$];
    int           got_t[$];
    int           done_t;
    int           done_n;

    always @(negedge clk) begin
        if (valid_out) begin
            got_d.push_back(vertex_out);
            got_t.push_back(cyc);
        end
        if (done_out) begin
            done_t = cyc;
            done_n = done_n + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0]     count;
        logic [7:0]      stall;
        logic            mid_start;
        logic [3:0]      n;
        logic [7:0]      base;
        logic [5:0][3:0] seq;
        logic [15:0]     skip;
        logic [11:0]     iaddr;
    } vec_t;

    vec_t vecs [4];
    vec_t dvec;

    task automatic run_vec(input vec_t v, input string nm);
        int s;
        int c;
        int exp_t;
        int last_t;
        bit seen;
        got_d.delete();
        got_t.delete();
        done_n = 0;
        ready_in = 1'b1;
        triangle_count_in = v.count;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        s = cyc;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            c = cyc - s;
            ready_in = !(v.stall != 0 && c >= 10 && c < 10 + int'(v.stall));
            if (v.mid_start)
                start_in = (c == 9);
            if (c == 3 && v.count != 0)
                chk({nm, " busy"}, 128'(busy_out), 128'd1);
            if (v.stall != 0 && c >= 11 && c <= 10 + int'(v.stall)) begin
                chk({nm, " stall valid"}, 128'(valid_out), 128'd0);
                chk({nm, " stall hold"}, vertex_out,
                    vertex_mem[v.seq[1]]);
            end
            if (done_n > 0) begin
                seen = 1'b1;
                break;
            end
        end
        start_in = 1'b0;
        ready_in = 1'b1;
        chk({nm, " done seen"}, 128'(seen), 128'd1);
        chk({nm, " transfers"}, 128'(got_d.size()), 128'(v.n));
        last_t = 0;
        for (int j = 0; j < int'(v.n); j++) begin
            exp_t = int'(v.base) + 15 * (j / 3) + 4 * (j % 3)
                    + ((j >= 1) ? int'(v.stall) : 0);
            last_t = exp_t;
            if (j < got_d.size()) begin
                chk($sformatf("%s data%0d", nm, j), got_d[j],
                    vertex_mem[v.seq[j]]);
                chk($sformatf("%s time%0d", nm, j), 128'(got_t[j] - s),
                    128'(exp_t));
            end
        end
        chk({nm, " done time"}, 128'(done_t - s),
            128'((v.n == 0) ? 1 : last_t + 1));
        @(posedge clk);
        #1;
        chk({nm, " busy after"}, 128'(busy_out), 128'd0);
        chk({nm, " skipped"}, 128'(skipped_count_out), 128'(v.skip));
        chk({nm, " iaddr"}, 128'(index_addr_out), 128'(v.iaddr));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        index_mem[0]  = {16'd2, 16'd1, 16'd0};
        index_mem[1]  = {16'd3, 16'd2, 16'd1};
        vertex_mem[0] = {32'hAAAAAAAA, 32'h3F000000, 32'h42200000, 32'h43200000};
        vertex_mem[1] = {32'hBBBBBBBB, 32'h3F800000, 32'h42A00000, 32'h42C80000};
        vertex_mem[2] = {32'hCCCCCCCC, 32'h3F800000, 32'h42C80000, 32'h43480000};
        vertex_mem[3] = {32'hDDDDDDDD, 32'h40000000, 32'h43000000, 32'h43800000};

        vecs[0] = '{count: 16'd1, stall: 8'd0, mid_start: 1'b0, n: 4'd3,
                    base: 8'd7, seq: {4'd0, 4'd0, 4'd0, 4'd2, 4'd1, 4'd0},
                    skip: 16'd0, iaddr: 12'd0};
        vecs[1] = '{count: 16'd1, stall: 8'd5, mid_start: 1'b0, n: 4'd3,
                    base: 8'd7, seq: {4'd0, 4'd0, 4'd0, 4'd2, 4'd1, 4'd0},
                    skip: 16'd0, iaddr: 12'd0};
        vecs[2] = '{count: 16'd2, stall: 8'd0, mid_start: 1'b1, n: 4'd6,
                    base: 8'd7, seq: {4'd3, 4'd2, 4'd1, 4'd2, 4'd1, 4'd0},
                    skip: 16'd0, iaddr: 12'd1};
        vecs[3] = '{count: 16'd0, stall: 8'd0, mid_start: 1'b0, n: 4'd0,
                    base: 8'd0, seq: '0, skip: 16'd0, iaddr: 12'd1};

        rst_n = 1'b0;
        start_in = 1'b0;
        ready_in = 1'b1;
        triangle_count_in = '0;
        done_n = 0;
        done_t = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs",
            {index_addr_out, vertex_addr_out, valid_out, busy_out,
             done_out, skipped_count_out, 70'd0},
            128'd0);
        chk("reset vertex", vertex_out, 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted during the second vertex fetch.
        got_d.delete();
        triangle_count_in = 16'd1;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst outputs",
            {index_addr_out, vertex_addr_out, valid_out, busy_out,
             done_out, skipped_count_out, 70'd0},
            128'd0);
        chk("midrst vertex", vertex_out, 128'd0);
        got_d.delete();
        repeat (20) @(posedge clk);
        #1;
        chk("midrst quiet", 128'(got_d.size()), 128'd0);
        run_vec(vecs[0], "after_rst");

        // Degenerate first triangle.
        index_mem[0] = {16'd1, 16'd1, 16'd0};
`ifdef VERTEX_FETCH_SKIP_DEGENERATE_EN
        dvec = '{count: 16'd2, stall: 8'd0, mid_start: 1'b0, n: 4'd3,
                 base: 8'd10, seq: {4'd0, 4'd0, 4'd0, 4'd3, 4'd2, 4'd1},
                 skip: 16'd1, iaddr: 12'd1};
`else
        dvec = '{count: 16'd2, stall: 8'd0, mid_start: 1'b0, n: 4'd6,
                 base: 8'd7, seq: {4'd3, 4'd2, 4'd1, 4'd1, 4'd1, 4'd0},
                 skip: 16'd0, iaddr: 12'd1};
`endif
        run_vec(dvec, "degen");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
